// File: rtl/mult_datapath.sv
// mult_datapath: X/A/B registers, add/sub adder and shift counter for a signed shift-add multiplier.
module mult_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Clr_Ld,
  input  logic             Load_B,
  input  logic             Shift,
  input  logic             Add,
  input  logic             Sub,
  input  logic [WIDTH-1:0] Sw,
  output logic             Xval,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             M,
  output logic [3:0]       Count,
  output logic             Done
);
  logic             x_q, x_d, done_q, done_d, xn;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, an;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH:0]   a_ext, s_ext, sum;
  always_comb begin
    a_ext    = {a_q[WIDTH-1], a_q};
    s_ext    = {Sw[WIDTH-1], Sw};
    sum      = Sub ? a_ext - s_ext : a_ext + s_ext;
    {xn, an} = (Add || Sub) ? sum : {x_q, a_q};
    x_d      = Clr_Ld ? 1'b0 : Load_B ? x_q : xn;
    a_d      = Clr_Ld ? '0 : Load_B ? a_q : Shift ? {xn, an[WIDTH-1:1]} : an;
    b_d      = (Clr_Ld || Load_B) ? (Load_B ? Sw : b_q) : Shift ? {an[0], b_q[WIDTH-1:1]} : b_q;
    cnt_d    = Clr_Ld ? 4'd0 : (Load_B || !Shift) ? cnt_q : (cnt_q < 4'd8) ? cnt_q + 4'd1 : 4'd1;
    done_d   = (cnt_d == 4'd8);
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_q    <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= 4'd0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      a_q    <= a_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end
  assign Xval  = x_q;
  assign Aval  = a_q;
  assign Bval  = b_q;
  assign M     = b_q[0];
  assign Count = cnt_q;
  assign Done  = done_q;
endmodule

// File: tb/tb_mult_datapath.sv
// tb_mult_datapath: directed vector checks of the multiplier datapath, including full FSM-style multiplies.
module tb_mult_datapath;
  logic       clk = 1'b0;
  logic       reset_n, clr_ld, load_b, shift, add, sub;
  logic [7:0] sw;
  logic       xval, m, done;
  logic [7:0] aval, bval;
  logic [3:0] count;
  int checks = 0;
  int failures = 0;

  mult_datapath #(.WIDTH(8)) dut (
    .Clk(clk), .Reset_n(reset_n), .Clr_Ld(clr_ld), .Load_B(load_b), .Shift(shift),
    .Add(add), .Sub(sub), .Sw(sw), .Xval(xval), .Aval(aval), .Bval(bval),
    .M(m), .Count(count), .Done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    logic [7:0]  s;
    logic [15:0] prod;
    logic        x;
  } mvec_t;

  mvec_t mv[8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmd(input logic c, input logic l, input logic sh, input logic ad, input logic sb, input logic [7:0] s);
    clr_ld = c; load_b = l; shift = sh; add = ad; sub = sb; sw = s;
    @(posedge clk);
    #1;
    clr_ld = 0; load_b = 0; shift = 0; add = 0; sub = 0;
  endtask

  task automatic do_mult(input logic [7:0] b, input logic [7:0] s);
    cmd(0, 1, 0, 0, 0, b);
    cmd(1, 0, 0, 0, 0, s);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("done_before_8th", {15'd0, done}, 16'd0);
      cmd(0, 0, 1, m && i < 7, m && i == 7, s);
    end
  endtask

  initial begin
    mv[0] = '{8'h03, 8'h07, 16'h0015, 1'b0};
    mv[1] = '{8'h03, 8'hF9, 16'hFFEB, 1'b1};
    mv[2] = '{8'hFD, 8'h07, 16'hFFEB, 1'b1};
    mv[3] = '{8'h80, 8'h80, 16'h4000, 1'b0};
    mv[4] = '{8'hFF, 8'hFF, 16'h0001, 1'b0};
    mv[5] = '{8'h7F, 8'h7F, 16'h3F01, 1'b0};
    mv[6] = '{8'h80, 8'h7F, 16'hC080, 1'b1};
    mv[7] = '{8'h00, 8'h55, 16'h0000, 1'b0};

    reset_n = 0; clr_ld = 0; load_b = 0; shift = 0; add = 0; sub = 0; sw = 8'h00;
    #12;
    check("reset_a", {8'd0, aval}, 16'h0000);
    check("reset_b", {8'd0, bval}, 16'h0000);
    check("reset_cnt_done_m", {10'd0, count, done, m}, 16'h0000);
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;

    // single-cycle add-then-shift
    cmd(0, 1, 0, 0, 0, 8'h01);
    cmd(1, 0, 0, 0, 0, 8'h05);
    cmd(0, 0, 1, 1, 0, 8'h05);
    check("single_xab", {xval, aval, bval[6:0]}, {1'b0, 8'h02, 7'h00});
    check("single_b", {8'd0, bval}, 16'h0080);
    check("single_cnt", {12'd0, count}, 16'd1);

    for (int i = 0; i < 8; i++) begin
      do_mult(mv[i].b, mv[i].s);
      check($sformatf("mult%0d_prod", i), {aval, bval}, mv[i].prod);
      check($sformatf("mult%0d_x", i), {15'd0, xval}, {15'd0, mv[i].x});
      check($sformatf("mult%0d_cnt_done", i), {11'd0, count, done}, {11'd0, 4'd8, 1'b1});
    end

    // chained shifts without clear wrap the counter
    for (int i = 1; i <= 8; i++) begin
      cmd(0, 0, 1, 0, 0, 8'h00);
      check($sformatf("chain_cnt%0d", i), {11'd0, count, done}, {11'd0, 4'(i), i == 8});
    end

    // priority: clear with load
    cmd(1, 1, 1, 1, 0, 8'h33);
    check("clr_ld_ab", {aval, bval}, 16'h0033);
    check("clr_ld_x_cnt", {11'd0, xval, count}, 16'd0);
    // add and sub together subtract
    cmd(0, 0, 0, 1, 1, 8'h05);
    check("addsub_xa", {7'd0, xval, aval}, 16'h01FB);
    // load with shift ignores the shift
    cmd(0, 1, 1, 1, 0, 8'h44);
    check("load_shift_ab", {aval, bval}, 16'hFB44);
    check("load_shift_x_cnt", {11'd0, xval, count}, 16'h0010);
    // idle holds
    cmd(0, 0, 0, 0, 0, 8'hAA);
    check("idle_hold", {aval, bval}, 16'hFB44);

    // asynchronous reset mid-operation
    cmd(1, 0, 0, 0, 0, 8'h5A);
    cmd(0, 0, 0, 1, 0, 8'h5A);
    check("pre_reset_a", {8'd0, aval}, 16'h005A);
    cmd(0, 0, 1, 0, 0, 8'h00);
    #2;
    reset_n = 0;
    #1;
    check("midreset_xab", {7'd0, xval, aval}, 16'h0000);
    check("midreset_b_cnt_done", {3'd0, bval, count, done}, 16'h0000);
    @(negedge clk);
    reset_n = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
